// File: rtl/tdm_demux_sequencer.sv
// Sequences a serial TDM bit stream into slots 0..7 for the 1-to-8 demux.
// It drives the data bit, the slot select lines and a masked enable, and reports frame status.
module tdm_demux_sequencer #(
  parameter int IDLE_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  input  logic [7:0]       chan_mask,
  output logic             D,
  output logic             S0,
  output logic             S1,
  output logic             S2,
  output logic             EN,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(IDLE_TIMEOUT - 1);

  state_t             r_state, w_state_next;
  logic [2:0]         r_slot, w_slot_next;
  logic [7:0]         r_idle_cnt, w_idle_next;
  logic               r_d, w_d_next;
  logic [2:0]         r_sel, w_sel_next;
  logic               r_en, w_en_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic               r_err, w_err_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_slot     <= 3'd0;
      r_idle_cnt <= 8'd0;
      r_d        <= 1'b0;
      r_sel      <= 3'd0;
      r_en       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_slot     <= w_slot_next;
      r_idle_cnt <= w_idle_next;
      r_d        <= w_d_next;
      r_sel      <= w_sel_next;
      r_en       <= w_en_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_err      <= w_err_next;
      r_cnt      <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_slot_next  = r_slot;
    w_idle_next  = r_idle_cnt;
    w_d_next     = r_d;
    w_sel_next   = r_sel;
    w_en_next    = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    w_cnt_next   = r_cnt;

    case (r_state)
      ST_IDLE: begin
        w_idle_next = 8'd0;
        if (din_valid && frame_sync) begin
          w_d_next     = din;
          w_sel_next   = 3'd0;
          w_en_next    = chan_mask[0];
          w_slot_next  = 3'd1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (din_valid) begin
          w_idle_next = 8'd0;
          // The slot is never 0 inside RUN, so any sync here is a resync.
          if (frame_sync) begin
            w_d_next    = din;
            w_sel_next  = 3'd0;
            w_en_next   = chan_mask[0];
            w_err_next  = 1'b1;
            w_slot_next = 3'd1;
          end else begin
            w_d_next   = din;
            w_sel_next = r_slot;
            w_en_next  = chan_mask[r_slot];
            if (r_slot == 3'd7) begin
              w_done_next  = 1'b1;
              w_cnt_next   = r_cnt + CNT_W'(1);
              w_slot_next  = 3'd0;
              w_state_next = ST_IDLE;
            end else begin
              w_slot_next = r_slot + 3'd1;
            end
          end
        end else if (r_idle_cnt == TIMEOUT_LAST) begin
          w_err_next   = 1'b1;
          w_idle_next  = 8'd0;
          w_slot_next  = 3'd0;
          w_state_next = ST_IDLE;
        end else begin
          w_idle_next = r_idle_cnt + 8'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_slot_next  = 3'd0;
        w_idle_next  = 8'd0;
      end
    endcase

    w_busy_next = (w_state_next == ST_RUN);
  end

  assign D          = r_d;
  assign S0         = r_sel[0];
  assign S1         = r_sel[1];
  assign S2         = r_sel[2];
  assign EN         = r_en;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign frame_err  = r_err;
  assign frame_cnt  = r_cnt;

endmodule

// File: tb/tb_tdm_demux_sequencer.sv
// Directed bench for tdm_demux_sequencer.
// Expected outputs are queued as each cycle is driven and popped after the clock edge.
module tb_tdm_demux_sequencer;

  logic       clk = 1'b0;
  logic       rst, din, din_valid, frame_sync;
  logic [7:0] chan_mask;
  logic       D, S0, S1, S2, EN, busy, frame_done, frame_err;
  logic [7:0] frame_cnt;

  tdm_demux_sequencer #(.IDLE_TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .chan_mask(chan_mask), .D(D), .S0(S0), .S1(S1), .S2(S2), .EN(EN), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       d;
    logic [2:0] s;
    logic       en;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   en_seen, done_seen, err_seen;

  // Reference state of the sequencer, kept by the bench.
  bit         m_run = 0;
  logic [2:0] m_slot = 0;
  int         m_idle = 0;
  logic [7:0] m_cnt = 0;
  logic       m_d = 0;
  logic [2:0] m_s = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic fs, input logic dd,
                      input logic [7:0] m, input string tag);
    exp_t e;
    rst = r; din_valid = v; frame_sync = fs; din = dd; chan_mask = m;
    e = '0;
    if (r) begin
      m_run = 0; m_slot = 0; m_idle = 0; m_cnt = 0; m_d = 0; m_s = 0;
    end else if (v) begin
      m_idle = 0;
      if (fs) begin
        if (m_run) e.err = 1'b1;
        m_d = dd; m_s = 3'd0; e.en = m[0];
        m_run = 1; m_slot = 3'd1;
      end else if (m_run) begin
        m_d = dd; m_s = m_slot; e.en = m[m_slot];
        if (m_slot == 3'd7) begin
          e.done = 1'b1; m_cnt = m_cnt + 8'd1; m_run = 0; m_slot = 3'd0;
        end else begin
          m_slot = m_slot + 3'd1;
        end
      end
    end else if (m_run) begin
      m_idle++;
      if (m_idle == 16) begin
        e.err = 1'b1; m_run = 0; m_slot = 3'd0; m_idle = 0;
      end
    end
    e.d = m_d; e.s = m_s; e.busy = m_run; e.cnt = m_cnt;
    q.push_back(e);

    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".D"},    32'(D),          32'(e.d));
    chk({tag, ".S"},    32'({S2, S1, S0}), 32'(e.s));
    chk({tag, ".EN"},   32'(EN),         32'(e.en));
    chk({tag, ".busy"}, 32'(busy),       32'(e.busy));
    chk({tag, ".done"}, 32'(frame_done), 32'(e.done));
    chk({tag, ".err"},  32'(frame_err),  32'(e.err));
    chk({tag, ".cnt"},  32'(frame_cnt),  32'(e.cnt));
    chk({tag, ".exclusive"}, 32'(frame_done & frame_err), 32'd0);
    en_seen   += int'(EN);
    done_seen += int'(frame_done);
    err_seen  += int'(frame_err);
  endtask

  // One frame, MSB of bits first; sync is also raised during gaps to show it is ignored.
  task automatic frame(input logic [7:0] bits, input logic [7:0] m, input int gap, input string tag);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, (i == 0), bits[7-i], m, tag);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b1, 1'b0, m, {tag, "_gap"});
    end
  endtask

  task automatic clr_seen();
    en_seen = 0; done_seen = 0; err_seen = 0;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; chan_mask = 8'h00;
    clr_seen();

    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, "rst");
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, "rst");
    chk("rst_outputs", 32'({D, S2, S1, S0, EN, busy, frame_done, frame_err}), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);

    // Full-mask frame 1,0,1,1,0,0,1,0.
    clr_seen();
    frame(8'b1011_0010, 8'hFF, 0, "f_full");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, "f_full_after");
    chk("f_full_en_cycles", 32'(en_seen), 32'd8);
    chk("f_full_done", 32'(done_seen), 32'd1);
    chk("f_full_cnt", 32'(frame_cnt), 32'd1);
    chk("f_full_hold_S", 32'({S2, S1, S0}), 32'd7);

    // Masked frame: EN only on slots 0, 2, 5, 7.
    clr_seen();
    frame(8'b1011_0010, 8'b1010_0101, 0, "f_mask");
    chk("f_mask_en_cycles", 32'(en_seen), 32'd4);
    chk("f_mask_done", 32'(done_seen), 32'd1);
    chk("f_mask_cnt", 32'(frame_cnt), 32'd2);

    // Unsynced bits in IDLE are dropped, then a frame with two-cycle gaps.
    clr_seen();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, "idle_drop");
    chk("idle_drop_en", 32'(en_seen), 32'd0);
    chk("idle_drop_busy", 32'(busy), 32'd0);
    frame(8'b0110_1001, 8'hFF, 2, "f_gap");
    chk("f_gap_en_cycles", 32'(en_seen), 32'd8);
    chk("f_gap_cnt", 32'(frame_cnt), 32'd3);

    // Resync on slot 4: error pulse, the new frame then completes once.
    clr_seen();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i == 0), 1'b1, 8'hFF, "resync_pre");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, "resync_bit");
    chk("resync_err_now", 32'(frame_err), 32'd1);
    chk("resync_S", 32'({S2, S1, S0}), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'(i), 8'hFF, "resync_post");
    chk("resync_err_total", 32'(err_seen), 32'd1);
    chk("resync_done", 32'(done_seen), 32'd1);
    chk("resync_cnt", 32'(frame_cnt), 32'd4);

    // Gap timeout after 3 bits.
    clr_seen();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, (i == 0), 1'b1, 8'hFF, "to_pre");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, "to_gap");
    chk("to_no_err_yet", 32'(err_seen), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, "to_gap16");
    chk("to_err", 32'(frame_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_cnt", 32'(frame_cnt), 32'd4);
    frame(8'b1100_0011, 8'hFF, 0, "to_fresh");
    chk("to_fresh_cnt", 32'(frame_cnt), 32'd5);
    chk("to_fresh_done", 32'(done_seen), 32'd1);

    // 256 back-to-back frames wrap the counter, then reset mid-frame.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, "wrap_rst");
    clr_seen();
    for (int f = 0; f < 256; f++) frame(8'(f), 8'hFF, 0, "b2b");
    chk("wrap_done", 32'(done_seen), 32'd256);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);
    clr_seen();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, (i == 0), 1'b1, 8'hFF, "abort_pre");
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, "abort_rst");
    chk("abort_outputs", 32'({D, S2, S1, S0, EN, busy, frame_done, frame_err}), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, "abort_after");
    chk("abort_no_err", 32'(err_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
